// File: rtl/or_gate_sweep_ctrl.sv
// or_gate_sweep_ctrl: sweeps every {a,b} vector, checks three OR-gate implementations, and records any failures
module or_gate_sweep_ctrl #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c_df,
  input  logic [WIDTH-1:0]   c_bh,
  input  logic [WIDTH-1:0]   c_st,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               fail_df,
  output logic               fail_bh,
  output logic               fail_st,
  output logic               fail_valid,
  output logic [2*WIDTH-1:0] fail_vec
);
  localparam int VW = 2 * WIDTH;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;
  state_t state_q, state_d;
  logic [VW-1:0] idx_q, idx_d, fail_vec_q, fail_vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_valid_q, fail_valid_d;
  logic fail_df_q, fail_df_d, fail_bh_q, fail_bh_d, fail_st_q, fail_st_d;
  logic [WIDTH-1:0] e;
  logic acc, chk, last, m_df, m_bh, m_st, mis;
  assign a = idx_q[VW-1:WIDTH];
  assign b = idx_q[WIDTH-1:0];
  always_comb begin
    e = a | b;
    acc = state_q == S_IDLE && start;
    chk = state_q == S_CHECK;
    last = idx_q == '1;
    m_df = chk && c_df != e;
    m_bh = chk && c_bh != e;
    m_st = chk && c_st != e;
    mis = m_df || m_bh || m_st;
    state_d = acc ? S_SETTLE
            : state_q == S_SETTLE ? (cnt_q == 8'd0 ? S_CHECK : S_SETTLE)
            : chk ? (last ? S_DONE : S_SETTLE)
            : state_q == S_DONE ? S_IDLE : state_q;
    cnt_d = (acc || chk) ? 8'(SETTLE - 1) : (state_q == S_SETTLE && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    idx_d = acc ? '0 : chk ? idx_q + VW'(1) : idx_q;
    busy_d = state_d == S_SETTLE || state_d == S_CHECK;
    done_d = state_d == S_DONE;
    err_d = acc ? '0 : (mis && err_q != '1) ? err_q + CNT_W'(1) : err_q;
    fail_df_d = !acc && (fail_df_q || m_df);
    fail_bh_d = !acc && (fail_bh_q || m_bh);
    fail_st_d = !acc && (fail_st_q || m_st);
    fail_valid_d = !acc && (fail_valid_q || mis);
    fail_vec_d = acc ? '0 : (mis && !fail_valid_q) ? idx_q : fail_vec_q;
    pass_d = acc ? 1'b0 : (chk && last) ? !(fail_valid_q || mis) : pass_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_df_q <= 1'b0;
      fail_bh_q <= 1'b0;
      fail_st_q <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_vec_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      fail_df_q <= fail_df_d;
      fail_bh_q <= fail_bh_d;
      fail_st_q <= fail_st_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q <= fail_vec_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err_cnt = err_q;
  assign fail_df = fail_df_q;
  assign fail_bh = fail_bh_q;
  assign fail_st = fail_st_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec = fail_vec_q;
endmodule

// File: tb/tb_or_gate_sweep_ctrl.sv
// tb_or_gate_sweep_ctrl: directed scoreboard bench for the OR-gate sweep controller
module tb_or_gate_sweep_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stuck = 1'b0;
  logic a, b, c_df, c_bh, c_st, busy, done, pass, fail_df, fail_bh, fail_st, fail_valid;
  logic [7:0] err_cnt;
  logic [1:0] fail_vec;
  logic a2, b2, busy2, done2, pass2, fdf2, fbh2, fst2, fv2;
  logic [0:0] err2;
  logic [1:0] fvec2;
  int checks = 0, failures = 0;
  logic [1:0] q[$];
  always #5 clk = ~clk;
  assign c_df = a | b;
  assign c_bh = stuck ? 1'b0 : (a | b);
  assign c_st = a | b;
  or_gate_sweep_ctrl #(.WIDTH(1), .SETTLE(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .c_df(c_df), .c_bh(c_bh), .c_st(c_st), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_df(fail_df), .fail_bh(fail_bh), .fail_st(fail_st),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );
  or_gate_sweep_ctrl #(.WIDTH(1), .SETTLE(2), .CNT_W(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a2), .b(b2),
    .c_df(1'b0), .c_bh(1'b0), .c_st(1'b0), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .fail_df(fdf2), .fail_bh(fbh2), .fail_st(fst2),
    .fail_valid(fv2), .fail_vec(fvec2)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic zero_chk(input string tag);
    chk(tag, {a, b, busy, done, pass, fail_df, fail_bh, fail_st, fail_valid, err_cnt, fail_vec,
              a2, b2, busy2, done2, pass2, fdf2, fbh2, fst2, fv2, err2, fvec2}, 32'd0);
  endtask
  task automatic sweep(input logic stk, input bit extra);
    int errs;
    logic [1:0] first;
    logic [1:0] v;
    errs = 0;
    first = 2'b00;
    stuck = stk;
    for (int k = 0; k < 4; k++) begin
      v = 2'(k);
      q.push_back(v);
      if (stk && (v[1] | v[0])) begin
        if (errs == 0) first = v;
        errs++;
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cleared_status", {pass, fail_df, fail_bh, fail_st, fail_valid, err_cnt, fail_vec}, 32'd0);
    chk("sat_cleared", {pass2, fdf2, fbh2, fst2, fv2, err2, fvec2}, 32'd0);
    for (int c = 1; c <= 13; c++) begin
      if (c < 13 && (c - 1) % 3 == 0) chk("vec_drive", {a, b}, q[0]);
      if (c < 13 && c % 3 == 0) chk("vec_check", {a, b}, q.pop_front());
      chk("done", done, c == 13);
      chk("busy", busy, c < 13);
      chk("sat_done", done2, c == 13);
      if (c == 7) chk("sat_err_after_01", err2, 1);
      if (extra && (c == 5 || c == 13)) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("idle_busy", busy, 0);
    chk("idle_ab", {a, b}, 0);
    chk("pass", pass, errs == 0);
    chk("err_cnt", err_cnt, errs);
    chk("fail_bh", fail_bh, errs != 0);
    chk("fail_df_st", {fail_df, fail_st}, 0);
    chk("fail_valid", fail_valid, errs != 0);
    chk("fail_vec", fail_vec, first);
    chk("sat_err", err2, 1);
    chk("sat_fail_vec", fvec2, 2'b01);
    chk("sat_flags", {fdf2, fbh2, fst2, fv2, pass2}, 5'b11110);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom);
      tick();
      zero_chk("reset_outputs");
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_no_busy", {busy, done, busy2}, 0);
    end
    sweep(1'b0, 1'b0);
    sweep(1'b1, 1'b1);
    sweep(1'b0, 1'b0);
    q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 6; i++) tick();
    chk("mid_vec_01", {a, b, busy}, 3'b011);
    rst_n = 1'b0;
    #1;
    zero_chk("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", busy, 0);
    sweep(1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
